uart_sample_framer: RTL and testbench

//  Sits directly downstream of the UART byte receiver in the input module.

---
 rtl/uart_framer_pkg.sv | 22 ++
 rtl/uart_sample_framer_if.sv | 30 +++
 rtl/sample_commit_fifo.sv | 64 ++++++
 rtl/uart_sample_framer.sv | 164 ++++++++++++++++
 tb/tb_uart_sample_framer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_framer_pkg.sv
// Shared types and defaults for the UART sample framer: FSM states, error codes
// and the default packet start marker.
package uart_framer_pkg;

    localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        LO,
        HI,
        CSUM
    } state_t;

    typedef enum logic [1:0] {
        ERR_LEN     = 2'd0,
        ERR_SPACE   = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_t;

endpackage

// File: rtl/uart_sample_framer_if.sv
// Byte-in / sample-out stream bundle of the framer, plus its packet status.
// master is the framer itself; slave is whatever feeds and drains it.
interface uart_sample_framer_if #(
    parameter int DEPTH = 128
) ();

    localparam int PW = $clog2(DEPTH) + 1;

    logic [7:0]    in_data;
    logic          in_valid;
    logic [15:0]   out_data;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          pkt_ok;
    logic          pkt_err;
    logic [1:0]    err_code;
    logic [PW-1:0] level;

    modport master (
        input  in_data, in_valid, out_ready,
        output out_data, out_last, out_valid, pkt_ok, pkt_err, err_code, level
    );

    modport slave (
        output in_data, in_valid, out_ready,
        input  out_data, out_last, out_valid, pkt_ok, pkt_err, err_code, level
    );

endinterface

// File: rtl/sample_commit_fifo.sv
// Show-ahead FIFO with a tentative write pointer: writes stay invisible to the
// reader until commit copies wr_tent to wr_commit; rewind discards them.
module sample_commit_fifo #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 17,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             commit,
    input  logic             rewind,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [PW-1:0]    level,
    output logic [PW-1:0]    free
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_tent;
    logic [PW-1:0]    wr_commit;
    logic [PW-1:0]    rd;

    // NOTE: storage has no reset; the pointers alone define what is valid, so
    // clearing them flushes the FIFO without a reset fan-out to every entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_tent[AW-1:0]] <= wr_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_tent   <= '0;
            wr_commit <= '0;
            rd        <= '0;
        end else begin
            if (rewind) begin
                wr_tent <= wr_commit;
            end else if (wr_en) begin
                wr_tent <= wr_tent + 1'b1;
            end
            if (commit) begin
                wr_commit <= wr_tent;
            end
            if (rd_en && rd_valid) begin
                rd <= rd + 1'b1;
            end
        end
    end

    // Pointers carry one extra wrap bit, so equal pointers mean empty and a
    // difference of DEPTH (MSBs differ, rest equal) means full.
    assign rd_valid = (rd != wr_commit);
    assign level    = wr_commit - rd;
    assign free     = PW'(DEPTH) - level;
    assign rd_data  = mem[rd[AW-1:0]];

endmodule

// File: rtl/uart_sample_framer.sv
// Packet framer behind the UART receiver: sync hunt, length/checksum parsing and
// commit-on-success buffering of 16-bit samples.
module uart_sample_framer
    import uart_framer_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC,
    parameter int         MAX_SAMPLES    = 64,
    parameter int         DEPTH          = 128,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input logic                  clk,
    input logic                  reset,
    uart_sample_framer_if.master bus
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    err_t          err_q;
    logic [7:0]    csum;
    logic [7:0]    lo_byte;
    logic [7:0]    remaining;
    logic [TW-1:0] tcnt;
    logic          pkt_ok_q;
    logic          pkt_err_q;

    logic          timeout_hit;
    logic          byte_ev;
    logic          len_bad;
    logic          len_no_space;
    logic          csum_match;
    logic          wr_en;
    logic          commit;
    logic          rewind;
    logic [16:0]   wr_data;
    logic [16:0]   rd_data;
    logic          rd_valid;
    logic [PW-1:0] level;
    logic [PW-1:0] free;

    // A timeout takes priority over a byte arriving in the same cycle.
    assign timeout_hit  = (state != HUNT) && (tcnt == T_LIMIT);
    assign byte_ev      = bus.in_valid && !timeout_hit;
    assign len_bad      = (bus.in_data == 8'd0) || (bus.in_data > 8'(MAX_SAMPLES));
    assign len_no_space = {8'd0, free} < {{PW{1'b0}}, bus.in_data};
    assign csum_match   = (bus.in_data == csum);
    assign wr_data      = {bus.in_data, lo_byte, remaining == 8'd1};

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves a value unassigned and infers a latch.
    always_comb begin
        wr_en  = 1'b0;
        commit = 1'b0;
        rewind = timeout_hit;
        if (byte_ev) begin
            case (state)
                LEN:     rewind = !len_bad && !len_no_space;
                HI:      wr_en  = 1'b1;
                CSUM: begin
                    commit = csum_match;
                    rewind = !csum_match;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            err_q     <= ERR_LEN;
            csum      <= '0;
            lo_byte   <= '0;
            remaining <= '0;
            tcnt      <= '0;
            pkt_ok_q  <= 1'b0;
            pkt_err_q <= 1'b0;
        end else begin
            pkt_ok_q  <= 1'b0;
            pkt_err_q <= 1'b0;
            if (timeout_hit) begin
                state     <= HUNT;
                pkt_err_q <= 1'b1;
                err_q     <= ERR_TIMEOUT;
                tcnt      <= '0;
            end else begin
                tcnt <= (state == HUNT || bus.in_valid) ? '0 : tcnt + 1'b1;
                if (bus.in_valid) begin
                    case (state)
                        HUNT: begin
                            if (bus.in_data == SYNC_BYTE) begin
                                state <= LEN;
                            end
                        end
                        LEN: begin
                            if (len_bad) begin
                                state     <= HUNT;
                                pkt_err_q <= 1'b1;
                                err_q     <= ERR_LEN;
                            end else if (len_no_space) begin
                                state     <= HUNT;
                                pkt_err_q <= 1'b1;
                                err_q     <= ERR_SPACE;
                            end else begin
                                remaining <= bus.in_data;
                                csum      <= bus.in_data;
                                state     <= LO;
                            end
                        end
                        LO: begin
                            lo_byte <= bus.in_data;
                            csum    <= csum ^ bus.in_data;
                            state   <= HI;
                        end
                        HI: begin
                            csum      <= csum ^ bus.in_data;
                            remaining <= remaining - 8'd1;
                            state     <= (remaining == 8'd1) ? CSUM : LO;
                        end
                        CSUM: begin
                            state <= HUNT;
                            if (csum_match) begin
                                pkt_ok_q <= 1'b1;
                            end else begin
                                pkt_err_q <= 1'b1;
                                err_q     <= ERR_CSUM;
                            end
                        end
                        default: state <= HUNT;
                    endcase
                end
            end
        end
    end

    sample_commit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (17)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .commit   (commit),
        .rewind   (rewind),
        .rd_en    (bus.out_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .level    (level),
        .free     (free)
    );

    // Data is masked when nothing is presented so idle/reset outputs read zero.
    assign bus.out_valid = rd_valid;
    assign bus.out_data  = rd_valid ? rd_data[16:1] : 16'd0;
    assign bus.out_last  = rd_valid && rd_data[0];
    assign bus.pkt_ok    = pkt_ok_q;
    assign bus.pkt_err   = pkt_err_q;
    assign bus.err_code  = err_q;
    assign bus.level     = level;

endmodule

// File: tb/tb_uart_sample_framer.sv
// Directed bench for uart_sample_framer: packet accept/reject, buffering limit,
// timeout, mid-packet reset and output stalls against hand-computed expectations.
module tb_uart_sample_framer;

    localparam int DEPTH       = 128;
    localparam int MAX_SAMPLES = 64;
    localparam int TIMEOUT     = 200;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_sample_framer_if #(.DEPTH(DEPTH)) bus ();

    uart_sample_framer #(
        .SYNC_BYTE      (8'hA5),
        .MAX_SAMPLES    (MAX_SAMPLES),
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    int valid_seen = 0;
    int stall_err = 0;
    logic        held_v = 1'b0;
    logic [16:0] held = '0;
    logic [16:0] obs_q[$];
    logic [16:0] exp_q[$];
    bit          done;

    // Observe on the falling edge, half a cycle clear of the active edge.
    always @(negedge clk) begin
        if (bus.pkt_ok)    ok_cnt++;
        if (bus.pkt_err)   err_cnt++;
        if (bus.out_valid) valid_seen++;
        if (held_v && bus.out_valid && ({bus.out_data, bus.out_last} !== held)) stall_err++;
        held_v = bus.out_valid && !bus.out_ready;
        held   = {bus.out_data, bus.out_last};
        if (bus.out_valid && bus.out_ready) obs_q.push_back({bus.out_data, bus.out_last});
    end

    task automatic send_byte(input logic [7:0] b);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_packet(input int n, input logic [7:0] hi, input logic [7:0] lo_base,
                               input bit bad);
        logic [7:0] cs;
        logic [7:0] lo;
        cs = 8'(n);
        send_byte(8'hA5);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            lo = lo_base + 8'(i);
            send_byte(lo);
            send_byte(hi);
            cs = cs ^ lo ^ hi;
            if (!bad) exp_q.push_back({hi, lo, i == n - 1});
        end
        send_byte(bad ? (cs ^ 8'h01) : cs);
    endtask

    task automatic wait_drained(input string name);
        int cyc;
        cyc = 0;
        while (bus.level != 0 && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (bus.level != 0) begin
            errors++;
            $display("FAIL %s drain timeout: level=%0d required 0", name, bus.level);
        end
        idle(3);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #2;
        checks++;
        if ({bus.out_valid, bus.pkt_ok, bus.pkt_err, bus.out_last} !== 4'b0000) begin
            errors++;
            $display("FAIL reset flags: got %b required 0000",
                     {bus.out_valid, bus.pkt_ok, bus.pkt_err, bus.out_last});
        end
        checks++;
        if (bus.level !== 8'd0 || bus.err_code !== 2'd0 || bus.out_data !== 16'h0) begin
            errors++;
            $display("FAIL reset values: level=%0d err_code=%0d out_data=%h required 0/0/0",
                     bus.level, bus.err_code, bus.out_data);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_good_packet;
        int ok0;
        ok0 = ok_cnt;
        obs_q.delete();
        bus.out_ready = 1'b1;
        send_byte(8'hA5); send_byte(8'h02);
        send_byte(8'h34); send_byte(8'h12);
        send_byte(8'h78); send_byte(8'h56);
        bus.in_data  = 8'h0A;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.pkt_ok !== 1'b1 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL good commit timing: pkt_ok=%b out_valid=%b required 1/1",
                     bus.pkt_ok, bus.out_valid);
        end
        checks++;
        if (bus.out_data !== 16'h1234 || bus.out_last !== 1'b0) begin
            errors++;
            $display("FAIL good head: got %h/%b required 1234/0", bus.out_data, bus.out_last);
        end
        idle(4);
        checks++;
        if (obs_q.size() != 2) begin
            errors++;
            $display("FAIL good count: got %0d required 2", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== {16'h1234, 1'b0} || obs_q[1] !== {16'h5678, 1'b1}) begin
                errors++;
                $display("FAIL good data: got %h %h required 02468 0acf1", obs_q[0], obs_q[1]);
            end
        end
        checks++;
        if (ok_cnt != ok0 + 1 || bus.level !== 8'd0) begin
            errors++;
            $display("FAIL good status: pkt_ok pulses=%0d level=%0d required 1/0",
                     ok_cnt - ok0, bus.level);
        end
    endtask

    task automatic test_bad_csum;
        int err0;
        int vs0;
        err0 = err_cnt;
        vs0  = valid_seen;
        send_byte(8'hA5); send_byte(8'h02);
        send_byte(8'h34); send_byte(8'h12);
        send_byte(8'h78); send_byte(8'h56);
        send_byte(8'h0B);
        idle(4);
        checks++;
        if (err_cnt != err0 + 1 || bus.err_code !== 2'd2) begin
            errors++;
            $display("FAIL csum err: pulses=%0d err_code=%0d required 1/2",
                     err_cnt - err0, bus.err_code);
        end
        checks++;
        if (valid_seen != vs0 || bus.level !== 8'd0) begin
            errors++;
            $display("FAIL csum visibility: valid cycles=%0d level=%0d required 0/0",
                     valid_seen - vs0, bus.level);
        end
    endtask

    task automatic test_bad_len;
        int err0;
        int ok0;
        err0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h00);
        idle(2);
        checks++;
        if (err_cnt != err0 + 1 || bus.err_code !== 2'd0) begin
            errors++;
            $display("FAIL len zero: pulses=%0d err_code=%0d required 1/0",
                     err_cnt - err0, bus.err_code);
        end
        send_byte(8'hA5); send_byte(8'h41);
        idle(2);
        checks++;
        if (err_cnt != err0 + 2 || bus.err_code !== 2'd0) begin
            errors++;
            $display("FAIL len 65: pulses=%0d err_code=%0d required 2/0",
                     err_cnt - err0, bus.err_code);
        end
        ok0 = ok_cnt;
        obs_q.delete();
        send_byte(8'hA5); send_byte(8'h01);
        send_byte(8'hCD); send_byte(8'hAB);
        send_byte(8'h67);
        idle(4);
        checks++;
        if (ok_cnt != ok0 + 1 || obs_q.size() != 1) begin
            errors++;
            $display("FAIL len recovery: pkt_ok=%0d samples=%0d required 1/1",
                     ok_cnt - ok0, obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== {16'hABCD, 1'b1}) begin
                errors++;
                $display("FAIL len recovery data: got %h required %h", obs_q[0], {16'hABCD, 1'b1});
            end
        end
    endtask

    task automatic test_no_space;
        int err0;
        int ok0;
        obs_q.delete();
        exp_q.delete();
        bus.out_ready = 1'b0;
        ok0 = ok_cnt;
        send_packet(64, 8'h10, 8'h00, 1'b0);
        send_packet(64, 8'h20, 8'h80, 1'b0);
        idle(2);
        checks++;
        if (bus.level !== 8'd128 || ok_cnt != ok0 + 2) begin
            errors++;
            $display("FAIL full level: level=%0d pkt_ok=%0d required 128/2", bus.level, ok_cnt - ok0);
        end
        err0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h01);
        send_byte(8'h22); send_byte(8'h11); send_byte(8'h33);
        idle(2);
        checks++;
        if (err_cnt != err0 + 1 || bus.err_code !== 2'd1 || bus.level !== 8'd128) begin
            errors++;
            $display("FAIL no space: pulses=%0d err_code=%0d level=%0d required 1/1/128",
                     err_cnt - err0, bus.err_code, bus.level);
        end
        bus.out_ready = 1'b1;
        wait_drained("no_space");
        checks++;
        if (obs_q.size() != 128) begin
            errors++;
            $display("FAIL drain count: got %0d required 128", obs_q.size());
        end else begin
            for (int i = 0; i < 128; i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL drain sample %0d: got %h required %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_timeout;
        int err0;
        int ok0;
        int vs0;
        int cyc;
        err0 = err_cnt;
        vs0  = valid_seen;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h34);
        idle(TIMEOUT - 10);
        checks++;
        if (err_cnt != err0) begin
            errors++;
            $display("FAIL timeout early: pulses=%0d required 0", err_cnt - err0);
        end
        cyc = 0;
        while (err_cnt == err0 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (err_cnt != err0 + 1 || bus.err_code !== 2'd3) begin
            errors++;
            $display("FAIL timeout err: pulses=%0d err_code=%0d required 1/3",
                     err_cnt - err0, bus.err_code);
        end
        checks++;
        if (valid_seen != vs0 || bus.level !== 8'd0) begin
            errors++;
            $display("FAIL timeout visibility: valid cycles=%0d level=%0d required 0/0",
                     valid_seen - vs0, bus.level);
        end
        ok0 = ok_cnt;
        send_packet(2, 8'h55, 8'h01, 1'b0);
        idle(4);
        checks++;
        if (ok_cnt != ok0 + 1) begin
            errors++;
            $display("FAIL timeout recovery: pkt_ok=%0d required 1", ok_cnt - ok0);
        end
    endtask

    task automatic test_reset_mid;
        int err0;
        int ok0;
        err0 = err_cnt;
        ok0  = ok_cnt;
        obs_q.delete();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        checks++;
        if (err_cnt != err0 || bus.level !== 8'd0) begin
            errors++;
            $display("FAIL hunt garbage: pulses=%0d level=%0d required 0/0", err_cnt - err0, bus.level);
        end
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h34); send_byte(8'h12);
        reset = 1'b1;
        #2;
        checks++;
        if ({bus.out_valid, bus.pkt_ok, bus.pkt_err} !== 3'b000 || bus.level !== 8'd0
            || bus.err_code !== 2'd0 || bus.out_data !== 16'h0) begin
            errors++;
            $display("FAIL mid reset: valid/ok/err=%b level=%0d err_code=%0d data=%h required 0",
                     {bus.out_valid, bus.pkt_ok, bus.pkt_err}, bus.level, bus.err_code, bus.out_data);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h0A);
        idle(4);
        checks++;
        if (ok_cnt != ok0 || err_cnt != err0 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL after reset: pkt_ok=%0d pkt_err=%0d samples=%0d required 0/0/0",
                     ok_cnt - ok0, err_cnt - err0, obs_q.size());
        end
    endtask

    task automatic test_stall;
        obs_q.delete();
        exp_q.delete();
        stall_err = 0;
        done = 1'b0;
        fork
            begin
                send_packet(5, 8'h40, 8'h10, 1'b0);
                send_packet(1, 8'h41, 8'hF0, 1'b0);
                send_packet(17, 8'h60, 8'h20, 1'b0);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 3) == 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_drained("stall");
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stall count: got %0d required %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL stall sample %0d: got %h required %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (stall_err != 0) begin
            errors++;
            $display("FAIL stall stability: changes while stalled=%0d required 0", stall_err);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        test_good_packet;
        test_bad_csum;
        test_bad_len;
        test_no_space;
        test_timeout;
        test_reset_mid;
        test_stall;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
